instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Encodes decoded instruction fields into 32-bit instruction words using the core's opcode map.
//  Streams the words into instruction memory as a program loader.
//  Forms the write-side counterpart of the control/ALU-control decode path; used by boot/test loaders.
//  Path: valid/ready field input -> combinational encoder -> FIFO -> sequential IMEM write port.
// PARAMETERS
//  DEPTH      4            FIFO entries; power of 2, >=2
//  AW         32           IMEM address width
//  BASE_ADDR  32'h0000_0000  first write address
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  load_start   in   1   pulse: begin load session (sampled in IDLE only)
//  in_valid     in   1   field bundle valid
//  in_ready     out  1   block accepts bundle this cycle
//  in_kind      in   3   0=R 1=LW 2=SW 3=BEQ 4=J 5=JAL; 6,7 illegal
//  in_rs/rt/rd  in   5   register fields (rd used by R only)
//  in_funct     in   6   R-type funct
//  in_imm       in   16  LW/SW/BEQ immediate
//  in_target    in   26  J/JAL target
//  in_last      in   1   bundle is final instruction of the session
//  imem_we      out  1   write strobe, one word per cycle
//  imem_addr    out  AW  byte address
//  imem_wdata   out  32  encoded word
//  busy         out  1   state != IDLE
//  done         out  1   one-cycle pulse: session complete
//  err          out  1   sticky: illegal bundle dropped; cleared by load_start or rst
//  word_count   out  16  words written this session
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; state IDLE; address = BASE_ADDR. Reset mid-session discards FIFO contents.
//  FSM: IDLE -load_start-> LOAD -(accept with in_last)-> FLUSH -(FIFO empty, last write issued)-> DONE -> IDLE.
//   - load_start outside IDLE is ignored.
//   - Entering LOAD: addr = BASE_ADDR, word_count = 0, err = 0.
//  Handshake: in_ready = (state==LOAD) && !fifo_full. Transfer on in_valid & in_ready.
//   - No pass-through when full. in_ready is 0 in IDLE, FLUSH and DONE.
//  Opcodes: R=10 LW=15 SW=43 BEQ=4 J=2 JAL=7.
//  Encoding:
//   - R: {op,rs,rt,rd,5'b0,funct}
//   - LW/SW/BEQ: {op,rs,rt,imm}
//   - J/JAL: {op,target}
//  Illegal kind: bundle accepted, not written; err set.
//   - If in_last is also set, the transition to FLUSH still occurs.
//  Drain: in LOAD/FLUSH with FIFO non-empty, pop one word per cycle.
//   - imem_we/addr/wdata are registered on the pop edge.
//   - addr += 4 after each write, wrapping modulo 2^AW.
//   - word_count saturates at 16'hFFFF.
//  Latency: bundle accepted at edge t into an empty FIFO -> imem_we high in the cycle after edge t+1.
//  Simultaneous push and pop allowed whenever not full; occupancy is unchanged.
//  done asserts in the cycle the FSM is in DONE, one cycle after the final imem_we cycle.
//   - Empty session (first bundle illegal+last): done one cycle after the FLUSH entry.
// CONFIGURATION
//  INSTR_ENC_FUNCT_CHECK_EN defined:
//   - R-type funct must be one of 32 (add), 34 (sub), 36 (and), 37 (or), 42 (slt).
//   - Any other funct is treated as illegal: dropped, err set.
//  INSTR_ENC_FUNCT_CHECK_EN undefined: any 6-bit funct is encoded verbatim.
// STRUCTURE
//  Shared package mips_pkg:
//   - opcode localparams (OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL)
//   - funct localparams (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT)
//   - kind encoding constants
//   - FSM state constants
//  Sub-module sync_fifo (WIDTH=32, DEPTH): full/empty flags, synchronous rst clears pointers.
//  Encoder is a combinational function inside this block.
// TESTING
//  1. R add rs=1 rt=2 rd=3 funct=32, last=1 -> one write, addr 0, wdata 32'h2822_1820, then done; word_count=1.
//  2. LW rs=4 rt=5 imm=8; J target=26'h100; JAL target=26'h40, last -> wdata
//     32'h3C85_0008, 32'h0800_0100, 32'h1C00_0040 at addr 0/4/8.
//  3. Hold IMEM-side full: push DEPTH+2 bundles back-to-back -> in_ready drops only when full.
//     Order preserved; no word lost or duplicated.
//  4. in_kind=6 between two valid bundles -> err=1; two writes at addr 0 and 4; the next load_start clears err.
//  5. rst asserted mid-LOAD with 3 words queued:
//     - next cycle all outputs 0, no further imem_we.
//     - new session restarts at BASE_ADDR.
//  6. With INSTR_ENC_FUNCT_CHECK_EN: funct=0 -> dropped, err=1; without the macro: written as 32'h2822_1800.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode/funct map, bundle kind codes and loader FSM states.
package mips_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [5:0] OP_R   = 6'd10;
  localparam logic [5:0] OP_LW  = 6'd15;
  localparam logic [5:0] OP_SW  = 6'd43;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_JAL = 6'd7;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  localparam logic [2:0] KIND_R   = 3'd0;
  localparam logic [2:0] KIND_LW  = 3'd1;
  localparam logic [2:0] KIND_SW  = 3'd2;
  localparam logic [2:0] KIND_BEQ = 3'd3;
  localparam logic [2:0] KIND_J   = 3'd4;
  localparam logic [2:0] KIND_JAL = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // True for the R-type functs the ALU-control decoder implements.
  function automatic logic is_alu_funct(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle input handshake and IMEM write port of the instruction loader.
interface instr_encoder_loader_if #(
  parameter int unsigned AW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_kind;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [5:0]    in_funct;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          in_last;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader_sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers; synchronous reset empties it.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam logic [PW:0] ONE = {{PW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wptr_q;
  logic [PW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + ONE;
      if (do_pop)  rptr_q <= rptr_q + ONE;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction field bundles into 32-bit words and streams them into IMEM.
// Build macro INSTR_ENC_FUNCT_CHECK_EN: drop R-type bundles whose funct is not add/sub/and/or/slt.
module instr_encoder_loader
  import mips_pkg::*;
#(
  parameter int unsigned   DEPTH     = 4,
  parameter int unsigned   AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start_i,
  instr_encoder_loader_if.slave bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [CNT_W-1:0]      word_count_o
);

  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                we_q;
  logic [AW-1:0]       addr_q;
  logic [AW-1:0]       next_addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    wcnt_q;

  logic                accept_c;
  logic                legal_c;
  logic                push_c;
  logic                pop_c;
  logic [WORD_W-1:0]   enc_word_c;
  logic [WORD_W-1:0]   fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;

  function automatic logic [WORD_W-1:0] encode(
    input logic [2:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [5:0]  funct,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [WORD_W-1:0] w;
    w = '0;
    case (kind)
      KIND_R:   w = {OP_R, rs, rt, rd, 5'b0, funct};
      KIND_LW:  w = {OP_LW, rs, rt, imm};
      KIND_SW:  w = {OP_SW, rs, rt, imm};
      KIND_BEQ: w = {OP_BEQ, rs, rt, imm};
      KIND_J:   w = {OP_J, target};
      KIND_JAL: w = {OP_JAL, target};
      default:  w = '0;
    endcase
    return w;
  endfunction

`ifdef INSTR_ENC_FUNCT_CHECK_EN
  assign legal_c = (bus.in_kind <= KIND_JAL) &&
                   ((bus.in_kind != KIND_R) || is_alu_funct(bus.in_funct));
`else
  assign legal_c = (bus.in_kind <= KIND_JAL);
`endif

  assign bus.in_ready = (state_q == ST_LOAD) && !fifo_full;
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign push_c       = accept_c && legal_c;
  assign pop_c        = ((state_q == ST_LOAD) || (state_q == ST_FLUSH)) && !fifo_empty;
  assign enc_word_c   = encode(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd,
                               bus.in_funct, bus.in_imm, bus.in_target);

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .wdata_i (enc_word_c),
    .pop_i   (pop_c),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Session FSM plus the registered IMEM write port fed by FIFO pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      next_addr_q <= BASE_ADDR;
      wdata_q     <= '0;
      wcnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= pop_c;
      if (pop_c) begin
        addr_q      <= next_addr_q;
        wdata_q     <= fifo_rdata;
        next_addr_q <= next_addr_q + AW'(4);
        if (wcnt_q != {CNT_W{1'b1}}) wcnt_q <= wcnt_q + CNT_W'(1);
      end
      if (accept_c && !legal_c) err_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (load_start_i) begin
            state_q     <= ST_LOAD;
            busy_q      <= 1'b1;
            next_addr_q <= BASE_ADDR;
            wcnt_q      <= '0;
            err_q       <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept_c && bus.in_last) state_q <= ST_FLUSH;
        end
        // An empty FIFO here means the final write has already been issued.
        ST_FLUSH: begin
          if (fifo_empty) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign word_count_o   = wcnt_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized bench for instr_encoder_loader against a queue-based reference of expected IMEM writes.
module tb_instr_encoder_loader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] word_count;

  always #5 clk = ~clk;

  instr_encoder_loader_if #(.AW(32)) bus ();

  instr_encoder_loader #(
    .DEPTH     (DEPTH),
    .AW        (32),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start_i (load_start),
    .bus          (bus),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .word_count_o (word_count)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } bundle_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  int      total = 0;
  int      bad = 0;
  int      cyc = 0;
  wr_t     exp_q[$];
  bundle_t prog[$];
  bundle_t cur;
  logic [31:0] m_addr;
  int      m_words;
  bit      m_err;
  int      last_sched;
  int      last_wr;
  int      a_last;
  bit      acc;
  bit      done_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int unsigned opcode_of(input logic [2:0] k);
    case (k)
      3'd0:    return 10;
      3'd1:    return 15;
      3'd2:    return 43;
      3'd3:    return 4;
      3'd4:    return 2;
      default: return 7;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input bundle_t b);
    logic [31:0] w;
    w = 32'(opcode_of(b.kind)) << 26;
    case (b.kind)
      3'd0:             w |= (32'(b.rs) << 21) | (32'(b.rt) << 16) | (32'(b.rd) << 11) | 32'(b.funct);
      3'd1, 3'd2, 3'd3: w |= (32'(b.rs) << 21) | (32'(b.rt) << 16) | 32'(b.imm);
      default:          w |= 32'(b.target);
    endcase
    return w;
  endfunction

  function automatic bit ref_legal(input bundle_t b);
    if (b.kind > 3'd5) return 1'b0;
`ifdef INSTR_ENC_FUNCT_CHECK_EN
    if (b.kind == 3'd0 && !(b.funct inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42})) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bundle_t mk(input int k, input int rs, input int rt, input int rd,
                                 input int fn, input int imm, input int tgt);
    bundle_t b;
    b.kind = 3'(k); b.rs = 5'(rs); b.rt = 5'(rt); b.rd = 5'(rd);
    b.funct = 6'(fn); b.imm = 16'(imm); b.target = 26'(tgt);
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    logic [5:0] fl [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    b.kind   = ($urandom_range(9, 0) == 0) ? 3'($urandom_range(7, 6)) : 3'($urandom_range(5, 0));
    b.rs     = 5'($urandom);
    b.rt     = 5'($urandom);
    b.rd     = 5'($urandom);
    b.funct  = ($urandom_range(3, 0) == 0) ? 6'($urandom) : fl[$urandom_range(4, 0)];
    b.imm    = 16'($urandom);
    b.target = 26'($urandom);
    return b;
  endfunction

  task automatic drive(input bundle_t b, input bit last);
    cur           = b;
    bus.in_kind   = b.kind;
    bus.in_rs     = b.rs;
    bus.in_rt     = b.rt;
    bus.in_rd     = b.rd;
    bus.in_funct  = b.funct;
    bus.in_imm    = b.imm;
    bus.in_target = b.target;
    bus.in_last   = last;
  endtask

  // One clock: sample at negedge, update the reference, return at posedge+1.
  // mode: 0 = idle/outside session, 1 = loading, 2 = draining after the last bundle.
  task automatic step(input int mode);
    bit exp_done;
    @(negedge clk);
    cyc++;
    if (bus.imem_we === 1'b1) begin
      last_wr = cyc;
      if (exp_q.size() == 0) chk("spurious_we", 64'(1), 64'(0));
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("waddr", 64'(bus.imem_addr), 64'(e.addr));
        chk("wdata", 64'(bus.imem_wdata), 64'(e.data));
        chk("wcycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (mode != 0) begin
      chk("busy", 64'(busy), 64'(1));
      chk("in_ready", 64'(bus.in_ready), 64'((mode == 1) && (exp_q.size() < DEPTH)));
    end
    if (mode == 2) begin
      exp_done = (exp_q.size() == 0) && (cyc >= a_last + 2) && (cyc >= last_wr + 1);
      chk("done", 64'(done), 64'(exp_done));
      if (exp_done) begin
        done_seen = 1'b1;
        chk("done_wcount", 64'(word_count), 64'(m_words));
        chk("done_err", 64'(err), 64'(m_err));
      end
    end
    acc = bus.in_valid && (bus.in_ready === 1'b1);
    if (acc) begin
      if (ref_legal(cur)) begin
        wr_t e;
        e.addr = m_addr;
        e.data = ref_word(cur);
        e.cyc  = (cyc + 2 > last_sched + 1) ? cyc + 2 : last_sched + 1;
        last_sched = e.cyc;
        exp_q.push_back(e);
        m_addr += 32'd4;
        m_words++;
      end else m_err = 1'b1;
      if (bus.in_last) a_last = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic begin_session();
    load_start = 1'b1;
    step(0);
    load_start = 1'b0;
    m_addr = 32'h0; m_words = 0; m_err = 1'b0; last_sched = 0;
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_err_clr", 64'(err), 64'(0));
    chk("start_wcount", 64'(word_count), 64'(0));
  endtask

  task automatic session(input int gap_max);
    int n;
    int guard;
    n = prog.size();
    begin_session();
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      bus.in_valid = 1'b0;
      for (int j = 0; j < g; j++) begin
        load_start = 1'($urandom_range(1, 0));
        step(1);
        load_start = 1'b0;
      end
      drive(prog[i], i == n - 1);
      bus.in_valid = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 20) begin
        step(1);
        guard++;
      end
      if (!acc) chk("accept_timeout", 64'(0), 64'(1));
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    done_seen = 1'b0;
    guard = 0;
    while (!done_seen && guard < 40) begin
      step(2);
      guard++;
    end
    if (!done_seen) chk("done_timeout", 64'(0), 64'(1));
    chk("done_pulse", 64'(done), 64'(0));
    chk("back_idle", 64'(busy), 64'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, 64'(bus.imem_we), 64'(0));
    chk({tag, "_addr"}, 64'(bus.imem_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(bus.imem_wdata), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
    chk({tag, "_wcount"}, 64'(word_count), 64'(0));
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'(0));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0), 1'b0);
    last_wr = 0; a_last = 0; last_sched = 0; m_addr = 0; m_words = 0; m_err = 1'b0;

    rst = 1'b1;
    step(0);
    step(0);
    chk_all_zero("reset");
    rst = 1'b0;
    step(0);

    // R add rs=1 rt=2 rd=3
    prog.delete();
    prog.push_back(mk(0, 1, 2, 3, 32, 0, 0));
    session(0);
    chk("t1_wdata", 64'(bus.imem_wdata), 64'(32'h2822_1820));
    chk("t1_addr", 64'(bus.imem_addr), 64'(0));
    chk("t1_wcount", 64'(word_count), 64'(1));

    // LW, J, JAL
    prog.delete();
    prog.push_back(mk(1, 4, 5, 0, 0, 8, 0));
    prog.push_back(mk(4, 0, 0, 0, 0, 0, 26'h100));
    prog.push_back(mk(5, 0, 0, 0, 0, 0, 26'h40));
    session(0);
    chk("t2_wdata", 64'(bus.imem_wdata), 64'(32'h1C00_0040));
    chk("t2_addr", 64'(bus.imem_addr), 64'(8));
    chk("t2_wcount", 64'(word_count), 64'(3));

    // DEPTH+2 back-to-back bundles
    prog.delete();
    for (int i = 0; i < DEPTH + 2; i++) prog.push_back(mk(i % 6, i, i + 1, i + 2, 32, i * 3, i * 5));
    session(0);
    chk("t3_wcount", 64'(word_count), 64'(DEPTH + 2));

    // illegal kind between two valid bundles
    prog.delete();
    prog.push_back(mk(0, 1, 2, 3, 34, 0, 0));
    prog.push_back(mk(6, 7, 7, 7, 0, 0, 0));
    prog.push_back(mk(2, 9, 10, 0, 0, 16'hBEEF, 0));
    session(0);
    chk("t4_err", 64'(err), 64'(1));
    chk("t4_addr", 64'(bus.imem_addr), 64'(4));
    chk("t4_wcount", 64'(word_count), 64'(2));

    // reset mid-LOAD with words in flight
    begin_session();
    drive(mk(0, 1, 2, 3, 32, 0, 0), 1'b0); bus.in_valid = 1'b1; step(1);
    chk("t5_acc0", 64'(acc), 64'(1));
    drive(mk(7, 0, 0, 0, 0, 0, 0), 1'b0); step(1);
    chk("t5_acc1", 64'(acc), 64'(1));
    drive(mk(1, 3, 4, 0, 0, 12, 0), 1'b0); step(1);
    chk("t5_acc2", 64'(acc), 64'(1));
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step(1);
    chk_all_zero("t5_rst");
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) step(0);
    prog.delete();
    prog.push_back(mk(3, 2, 3, 0, 0, 16'hFFFC, 0));
    prog.push_back(mk(0, 4, 5, 6, 42, 0, 0));
    session(0);
    chk("t5_restart_addr", 64'(bus.imem_addr), 64'(4));

    // R-type with funct 0
    prog.delete();
    prog.push_back(mk(0, 1, 2, 3, 0, 0, 0));
    session(0);
`ifdef INSTR_ENC_FUNCT_CHECK_EN
    chk("t6_err", 64'(err), 64'(1));
    chk("t6_wcount", 64'(word_count), 64'(0));
`else
    chk("t6_wdata", 64'(bus.imem_wdata), 64'(32'h2822_1800));
    chk("t6_err", 64'(err), 64'(0));
`endif

    // randomized sessions with idle gaps and stray load_start pulses
    for (int s = 0; s < 10; s++) begin
      int n;
      n = int'($urandom_range(10, 1));
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(rand_bundle());
      session(2);
      step(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
